ddr3_burst_tester: RTL
======================

Name: ddr3_burst_tester

Overview:
Parametrised DDR3 Avalon-MM traffic generator and checker for the DDRAM port. It issues configurable write bursts, read bursts, or write-then-verify bursts with a deterministic data pattern, and counts readback mismatches. It supports safe stop, unsafe abort, and a fault-injection abort that holds WE high. It sits between the emu top level (which supplies cfg from status bits) and the DDRAM_* pins, in the clk_ddr3 domain.

Parameters:
ADDR_W, 29, DDRAM word-address width.
DATA_W, 64, data width; must be ≥32.
BURST_W, 8, burstcount width; maximum burst length is 2^BURST_W-1.
WAIT_W, 10, inter-burst wait counter width.

Ports:
clk  in  1  clk_ddr3; all logic on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
cfg_mode  in  2  0 = write only, 1 = read only, 2 = write-then-verify, 3 = reserved (treated as 0).
cfg_burst_len  in  BURST_W  beats per burst; 0 is treated as 1.
cfg_wait  in  WAIT_W  idle cycles between bursts.
cfg_base  in  ADDR_W  first burst address.
cfg_incr  in  1  1 = each burst starts at base+n*len; 0 = every burst at base.
cfg_num_bursts  in  16  number of bursts; 0 = endless.
cfg_be  in  DATA_W/8  write byte enable and compare mask.
cfg_abort_we  in  1  after abort, hold ddr_we high.
start  in  1  pulse; begins a run from IDLE or DONE.
safe_stop  in  1  pulse; finish the current burst (and its verify), then stop.
abort  in  1  pulse; stop immediately, possibly mid-burst.
ddr_busy  in  1  waitrequest.
ddr_burstcnt  out  BURST_W  burstcount.
ddr_addr  out  ADDR_W  burst address.
ddr_rd  out  1  read request.
ddr_we  out  1  write strobe.
ddr_din  out  DATA_W  write data.
ddr_be  out  DATA_W/8  byte enable.
ddr_dout  in  DATA_W  read data.
ddr_dout_ready  in  1  read data valid.
running  out  1  high in any state other than IDLE and DONE.
done  out  1  high in DONE.
aborted  out  1  the last run ended via abort.
err_count  out  16  masked mismatches; saturates at 16'hFFFF.
first_err_addr  out  ADDR_W  beat address of the first mismatch.
beats_wr  out  32  accepted write beats; wraps.
beats_rd  out  32  received read beats; wraps.

Behaviour:
- Reset (async assert, sync deassert expected from the caller): state IDLE; ddr_we=0, ddr_rd=0, ddr_burstcnt=0, ddr_addr=0, ddr_din=0, ddr_be=0; all status outputs 0.
- States: IDLE, WAIT, WR, RD_REQ, RD_DATA, DONE.
- start in IDLE/DONE: latch all cfg_* inputs, clear counters, flags and burst index n, go to WAIT. start is ignored while running. cfg_* changes mid-run have no effect.
- WAIT: count cfg_wait cycles. cfg_wait=0 leaves WAIT after exactly 1 cycle. On exit go to WR (modes 0/2) or RD_REQ (mode 1).
- Burst address A = cfg_base + (cfg_incr ? n*len : 0), computed modulo 2^ADDR_W. Beat address for beat k is A+k.
- Pattern for beat k: bits[31:0] = zero-extended beat address (A+k); bits[DATA_W-1:32] = n, zero-extended or truncated to fit.
- WR: ddr_we=1 and ddr_be=cfg_be. Outputs are held stable while ddr_busy=1. A beat is accepted when ddr_we & !ddr_busy; k then increments.
  - ddr_burstcnt and ddr_addr are valid on all beats, so burstcount is constant for the whole burst.
  - After the last accepted beat: mode 2 goes to RD_REQ for the same A; mode 0 finishes the burst.
- RD_REQ: ddr_rd=1 with A and len, held until !ddr_busy. The request occupies 1 accepted cycle, then go to RD_DATA.
- RD_DATA: each ddr_dout_ready beat is compared with the expected pattern under the cfg_be byte mask. On mismatch, err_count++ (saturating); the first mismatch of the run captures its beat address. After len beats, finish the burst.
- Burst finish: n++. Go to DONE if safe_stop is pending or n reaches cfg_num_bursts (non-zero); otherwise go to WAIT.
- safe_stop: latched as pending in any running state and cleared on start. In IDLE/DONE it has no effect.
- abort: on the next edge go to DONE with aborted=1, dropping ddr_we and ddr_rd even mid-burst, unless cfg_abort_we is set. With cfg_abort_we=1, ddr_we stays 1 in DONE until the next start or reset.
  - Read beats arriving in DONE are ignored.
  - abort has priority over safe_stop and burst finish in the same cycle.
- Simultaneous accepted beat and abort: the beat is counted, then the run stops.
- beats_wr and beats_rd wrap at 2^32. n wraps at 2^16, which is only reachable in endless mode.

Decomposition:
- Package ddr3_burst_pkg: state enum; mode enum (MODE_WR, MODE_RD, MODE_WRV); pattern function f(n, beat_addr) returning DATA_W bits.
- Sub-module ddr3_burst_checker: masked compare, saturating err_count, first_err_addr capture. It is cleared by start.

Test Plan:
1. Mode 0, len=4, base=0x2400000, incr=1, num=2, busy=0 → 8 WE beats. Burst 0 uses addr 0x2400000; burst 1 uses 0x2400004. Beat 5 data = {32'd1, 32'h2400005}. done=1, beats_wr=8.
2. Mode 2, len=128, busy toggled every other cycle; memory model echoes written data → each WR is followed by an RD of the same A and burstcnt=128. Outputs stay stable under busy. err_count=0, beats_rd=beats_wr.
3. Mode 2, be=8'h0F, model corrupts byte 5 of beat 3 of burst 0 → err_count=0, because the byte is masked. Corrupting byte 1 instead → err_count=1, first_err_addr=base+3.
4. Endless mode 0, safe_stop pulsed at beat 10 of len=16 → beats_wr reaches a multiple of 16, then done=1, aborted=0.
5. Abort at beat 10 of len=16 with cfg_abort_we=0 → ddr_we=0 next cycle, aborted=1, beats_wr=11. With cfg_abort_we=1 → ddr_we stays 1 until start.
6. reset_n low mid-WR with busy=1 → all outputs 0 immediately and asynchronously. A subsequent start with cfg_wait=0 → first WE 2 cycles after start.

Source files
------------

// File: rtl/ddr3_burst_pkg.sv
// Shared types and the deterministic beat data pattern for the DDR3 burst tester.
package ddr3_burst_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_WR, S_RD_REQ, S_RD_DATA, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_WR  = 2'd0,
        MODE_RD  = 2'd1,
        MODE_WRV = 2'd2,
        MODE_RSV = 2'd3
    } mode_t;

    localparam int PAT_W = 48;

    // Beat address in the low word, burst index above it; callers resize to DATA_W.
    function automatic logic [PAT_W-1:0] burst_pattern(input logic [15:0] n,
                                                       input logic [31:0] beat_addr);
        return {n, beat_addr};
    endfunction

endpackage

// File: rtl/ddr3_burst_checker.sv
// Masked readback compare with a saturating error count and first-error address capture.
module ddr3_burst_checker
    import ddr3_burst_pkg::*;
#(
    parameter int ADDR_W = 29,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_clr,
    input  logic                i_vld,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [DATA_W-1:0]   i_exp,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [15:0]         o_err_count,
    output logic [ADDR_W-1:0]   o_first_err_addr
);

    logic [DATA_W-1:0] w_mask;
    logic              w_mis;
    logic [15:0]       r_err;
    logic [ADDR_W-1:0] r_first;
    logic              r_have;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DATA_W/8; i++)
            w_mask[i*8 +: 8] = {8{i_be[i]}};
    end

    assign w_mis = |((i_data ^ i_exp) & w_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err   <= '0;
            r_first <= '0;
            r_have  <= 1'b0;
        end else if (i_clr) begin
            r_err   <= '0;
            r_first <= '0;
            r_have  <= 1'b0;
        end else if (i_vld && w_mis) begin
            if (r_err != 16'hFFFF)
                r_err <= r_err + 16'd1;
            if (!r_have) begin
                r_have  <= 1'b1;
                r_first <= i_addr;
            end
        end
    end

    assign o_err_count      = r_err;
    assign o_first_err_addr = r_first;

endmodule

// File: rtl/ddr3_burst_tester.sv
// Avalon-MM DDR3 traffic generator: write, read or write-then-verify bursts with a
// deterministic pattern, safe stop, abort, and an abort mode that leaves WE asserted.
module ddr3_burst_tester
    import ddr3_burst_pkg::*;
#(
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 8,
    parameter int WAIT_W  = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          cfg_mode,
    input  logic [BURST_W-1:0]  cfg_burst_len,
    input  logic [WAIT_W-1:0]   cfg_wait,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic                cfg_incr,
    input  logic [15:0]         cfg_num_bursts,
    input  logic [DATA_W/8-1:0] cfg_be,
    input  logic                cfg_abort_we,
    input  logic                start,
    input  logic                safe_stop,
    input  logic                abort,
    input  logic                ddr_busy,
    output logic [BURST_W-1:0]  ddr_burstcnt,
    output logic [ADDR_W-1:0]   ddr_addr,
    output logic                ddr_rd,
    output logic                ddr_we,
    output logic [DATA_W-1:0]   ddr_din,
    output logic [DATA_W/8-1:0] ddr_be,
    input  logic [DATA_W-1:0]   ddr_dout,
    input  logic                ddr_dout_ready,
    output logic                running,
    output logic                done,
    output logic                aborted,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [31:0]         beats_wr,
    output logic [31:0]         beats_rd
);

    state_t                r_state, w_next;
    mode_t                 r_mode;
    logic [BURST_W-1:0]    r_len, r_k;
    logic [WAIT_W-1:0]     r_wait, r_wcnt;
    logic [ADDR_W-1:0]     r_base;
    logic                  r_incr, r_abort_we;
    logic [15:0]           r_num, r_n;
    logic [DATA_W/8-1:0]   r_be;
    logic                  r_stop_pend, r_aborted, r_we_hold;
    logic [31:0]           r_beats_wr, r_beats_rd;

    logic                  w_running, w_start, w_last, w_wait_done, w_stop;
    logic                  w_wr_acc, w_rd_beat, w_burst_end;
    logic [15+BURST_W:0]   w_prod;
    logic [ADDR_W-1:0]     w_a, w_beat_addr;
    logic [DATA_W-1:0]     w_pat;

    assign w_running   = !(r_state == S_IDLE || r_state == S_DONE);
    assign w_start     = start && !w_running;
    assign w_prod      = {{BURST_W{1'b0}}, r_n} * {16'b0, r_len};
    assign w_a         = r_base + (r_incr ? ADDR_W'(w_prod) : '0);
    assign w_beat_addr = w_a + ADDR_W'(r_k);
    assign w_pat       = DATA_W'(burst_pattern(r_n, 32'(w_beat_addr)));
    assign w_last      = (r_k == r_len - BURST_W'(1));
    assign w_wait_done = ((WAIT_W+1)'(r_wcnt) + (WAIT_W+1)'(1)) >= (WAIT_W+1)'(r_wait);
    assign w_wr_acc    = (r_state == S_WR) && !ddr_busy;
    assign w_rd_beat   = (r_state == S_RD_DATA) && ddr_dout_ready;
    assign w_burst_end = (w_wr_acc && w_last && r_mode != MODE_WRV) || (w_rd_beat && w_last);
    assign w_stop      = r_stop_pend || safe_stop || (r_num != '0 && r_n + 16'd1 == r_num);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        ddr_we       = 1'b0;
        ddr_rd       = 1'b0;
        ddr_burstcnt = '0;
        ddr_addr     = '0;
        ddr_din      = '0;
        ddr_be       = '0;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_WAIT;
            S_WAIT:    if (w_wait_done) w_next = (r_mode == MODE_RD) ? S_RD_REQ : S_WR;
            S_WR:      if (w_wr_acc && w_last)
                           w_next = (r_mode == MODE_WRV) ? S_RD_REQ : (w_stop ? S_DONE : S_WAIT);
            S_RD_REQ:  if (!ddr_busy) w_next = S_RD_DATA;
            S_RD_DATA: if (w_rd_beat && w_last) w_next = w_stop ? S_DONE : S_WAIT;
            default:   w_next = S_IDLE;
        endcase
        if (w_running && abort) w_next = S_DONE;
        // Burstcount and address are presented on every write beat, not just the first.
        if (r_state == S_WR || (r_state == S_DONE && r_we_hold)) begin
            ddr_we       = 1'b1;
            ddr_din      = w_pat;
            ddr_be       = r_be;
            ddr_burstcnt = r_len;
            ddr_addr     = w_a;
        end
        if (r_state == S_RD_REQ) begin
            ddr_rd       = 1'b1;
            ddr_burstcnt = r_len;
            ddr_addr     = w_a;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= MODE_WR;  r_len <= '0;  r_wait <= '0;  r_base <= '0;
            r_incr <= 1'b0;     r_num <= '0;  r_be <= '0;    r_abort_we <= 1'b0;
            r_n <= '0;  r_k <= '0;  r_wcnt <= '0;
            r_stop_pend <= 1'b0;  r_aborted <= 1'b0;  r_we_hold <= 1'b0;
            r_beats_wr <= '0;  r_beats_rd <= '0;
        end else if (w_start) begin
            r_mode     <= (cfg_mode == MODE_RSV) ? MODE_WR : mode_t'(cfg_mode);
            r_len      <= (cfg_burst_len == '0) ? BURST_W'(1) : cfg_burst_len;
            r_wait     <= cfg_wait;
            r_base     <= cfg_base;
            r_incr     <= cfg_incr;
            r_num      <= cfg_num_bursts;
            r_be       <= cfg_be;
            r_abort_we <= cfg_abort_we;
            r_n <= '0;  r_k <= '0;  r_wcnt <= '0;
            r_stop_pend <= 1'b0;  r_aborted <= 1'b0;  r_we_hold <= 1'b0;
            r_beats_wr <= '0;  r_beats_rd <= '0;
        end else begin
            if (w_wr_acc)  r_beats_wr <= r_beats_wr + 32'd1;
            if (w_rd_beat) r_beats_rd <= r_beats_rd + 32'd1;
            if (r_state == S_WAIT) r_wcnt <= w_wait_done ? '0 : r_wcnt + WAIT_W'(1);
            if (w_wr_acc || w_rd_beat) r_k <= w_last ? '0 : r_k + BURST_W'(1);
            if (w_burst_end) r_n <= r_n + 16'd1;
            if (w_running && safe_stop) r_stop_pend <= 1'b1;
            // A beat accepted in the abort cycle has already been counted above.
            if (w_running && abort) begin
                r_aborted <= 1'b1;
                r_we_hold <= r_abort_we;
            end
        end
    end

    ddr3_burst_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_chk (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_clr            (w_start),
        .i_vld            (w_rd_beat),
        .i_data           (ddr_dout),
        .i_exp            (w_pat),
        .i_be             (r_be),
        .i_addr           (w_beat_addr),
        .o_err_count      (err_count),
        .o_first_err_addr (first_err_addr)
    );

    assign running  = w_running;
    assign done     = (r_state == S_DONE);
    assign aborted  = r_aborted;
    assign beats_wr = r_beats_wr;
    assign beats_rd = r_beats_rd;

endmodule
